mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 DW-bit mux datapath between four requesters (a, b, c, d).
- Drives the mux select and enable.
- Returns a registered copy of the selected data with a valid flag.
- Sits in front of the shared mux. Requesters hold req high while they want the mux; a grant lasts at most MAX_HOLD cycles.

---
 rtl/mux_rr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: four-requester round-robin arbiter that owns the select
// and enable of a shared 4:1 DW-bit mux and registers the mux output.
// A grant lasts at most MAX_HOLD consecutive cycles before re-arbitration.
// Optional feature macro: MUX_ARB_LOCK_EN adds a per-requester lock input
// that lets the current owner suppress the MAX_HOLD expiry.
module mux_rr_arbiter #(
  parameter int unsigned DW       = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
`ifdef MUX_ARB_LOCK_EN
  input  logic [3:0]    lock,
`endif
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic          en,
  output logic [DW-1:0] z,
  output logic          z_valid
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t        r_state;
  logic [3:0]    r_gnt;
  logic [1:0]    r_sel;
  logic          r_en;
  logic [1:0]    r_last;
  logic [3:0]    r_hold_cnt;
  logic [DW-1:0] r_z;
  logic          r_z_valid;

  logic          w_pick_found;
  logic [1:0]    w_pick_idx;
  logic          w_own_req;
  logic          w_below_max;
  logic          w_lock_hold;
  logic          w_continue;
  logic [DW-1:0] w_mux_out;

  // Round-robin pick: first set request scanning last+1, last+2, ... mod 4.
  // In GRANT, last equals the owner, so the owner is scanned last; this also
  // covers the expired-but-still-requesting regrant without a special case.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!w_pick_found && req[r_last + 2'(i)]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = r_last + 2'(i);
      end
    end
  end

  assign w_own_req   = req[r_sel];
  assign w_below_max = (r_hold_cnt < MAX_HOLD_C);

`ifdef MUX_ARB_LOCK_EN
  // Only the owner's lock bit matters; non-owner locks are ignored.
  assign w_lock_hold = lock[r_sel];
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_continue = (r_state == S_GRANT) && w_own_req
                      && (w_below_max || w_lock_hold);

  // Shared 4:1 mux driven by the registered select.
  always_comb begin
    w_mux_out = '0;
    unique case (r_sel)
      2'd0: w_mux_out = a;
      2'd1: w_mux_out = b;
      2'd2: w_mux_out = c;
      2'd3: w_mux_out = d;
    endcase
  end

  // Arbitration FSM; gnt, sel and en are always updated together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_en       <= 1'b0;
      r_last     <= 2'd3;
      r_hold_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pick_found) begin
            r_state    <= S_GRANT;
            r_gnt      <= 4'b0001 << w_pick_idx;
            r_sel      <= w_pick_idx;
            r_en       <= 1'b1;
            r_last     <= w_pick_idx;
            r_hold_cnt <= 4'd1;
          end
        end
        S_GRANT: begin
          if (w_continue) begin
            // Saturates at MAX_HOLD while a lock keeps the owner in place.
            if (w_below_max) begin
              r_hold_cnt <= r_hold_cnt + 4'd1;
            end
          end else if (w_pick_found) begin
            r_gnt      <= 4'b0001 << w_pick_idx;
            r_sel      <= w_pick_idx;
            r_en       <= 1'b1;
            r_last     <= w_pick_idx;
            r_hold_cnt <= 4'd1;
          end else begin
            // sel deliberately keeps its last value when going idle.
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_en       <= 1'b0;
            r_hold_cnt <= '0;
          end
        end
      endcase
    end
  end

  // Registered mux output; holds while no grant is active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_z       <= '0;
      r_z_valid <= 1'b0;
    end else begin
      r_z_valid <= r_en;
      if (r_en) begin
        r_z <= w_mux_out;
      end
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign en      = r_en;
  assign z       = r_z;
  assign z_valid = r_z_valid;

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(r_gnt));
  a_en_with_gnt : assert property (@(posedge clk) disable iff (!rst_n)
    r_en == (r_gnt != '0));
  a_hold_bound  : assert property (@(posedge clk) disable iff (!rst_n)
    r_hold_cnt <= MAX_HOLD_C);
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed vector table, hand sequences for
// rotation/expiry/lock, and randomized traffic against a behavioural model.
module tb_mux_rr_arbiter;

  localparam int unsigned DW       = 4;
  localparam int unsigned MAX_HOLD = 4;
`ifdef MUX_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = '0;
  logic [3:0]    lock = '0;
  logic [DW-1:0] dat [4];
  logic [DW-1:0] a, b, c, d;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          en;
  logic [DW-1:0] z;
  logic          z_valid;

  int n_checks = 0;
  int n_errors = 0;

  assign a = dat[0];
  assign b = dat[1];
  assign c = dat[2];
  assign d = dat[3];

  mux_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
`ifdef MUX_ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .sel     (sel),
    .en      (en),
    .z       (z),
    .z_valid (z_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rstn;
    logic [3:0]    req;
    logic [DW-1:0] da, db, dc, dd;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          en;
    logic [DW-1:0] z;
    logic          zv;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  // Behavioural reference: owner/count/last tracked as plain integers.
  bit            m_busy;
  int            m_sel, m_cnt, m_last;
  logic [DW-1:0] m_z;
  bit            m_zv;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] outs();
    return 16'({gnt, sel, en, z, z_valid});
  endfunction

  task automatic model_edge(input bit rstn, input logic [3:0] rq, input logic [3:0] lk);
    bit keep;
    if (!rstn) begin
      m_busy = 0; m_sel = 0; m_cnt = 0; m_last = 3; m_z = '0; m_zv = 0;
      return;
    end
    if (m_busy) m_z = dat[m_sel];
    m_zv = m_busy;
    keep = m_busy && rq[m_sel] && (m_cnt < MAX_HOLD || (LOCK_EN && lk[m_sel]));
    if (keep) begin
      if (m_cnt < MAX_HOLD) m_cnt = m_cnt + 1;
    end else if (rq != 4'b0) begin
      for (int j = 1; j <= 4; j++) begin
        int k;
        k = (m_last + j) % 4;
        if (rq[k]) begin
          m_sel = k; m_last = k; m_cnt = 1; m_busy = 1;
          break;
        end
      end
    end else begin
      m_busy = 0;
    end
  endtask

  function automatic logic [15:0] model_outs();
    logic [3:0] g;
    g = m_busy ? 4'(1 << m_sel) : 4'b0;
    return 16'({g, 2'(m_sel), m_busy, m_z, m_zv});
  endfunction

  initial begin
    logic [DW-1:0] rr_dat [4];
    logic [DW-1:0] exp_z;
    logic          exp_zv;
    int            owner, prev;

    dat = '{4'h0, 4'h0, 4'h0, 4'h0};

    // rstn, req, a, b, c, d, gnt, sel, en, z, z_valid
    vecs[0]  = '{1'b0, 4'hF, 4'h4, 4'h0, 4'h1, 4'hD, 4'b0000, 2'd0, 1'b0, 4'h0, 1'b0};
    vecs[1]  = '{1'b0, 4'hF, 4'h4, 4'h0, 4'h1, 4'hD, 4'b0000, 2'd0, 1'b0, 4'h0, 1'b0};
    vecs[2]  = '{1'b1, 4'hF, 4'h4, 4'h0, 4'h1, 4'hD, 4'b0001, 2'd0, 1'b1, 4'h0, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 4'h4, 4'h0, 4'h1, 4'hD, 4'b0000, 2'd0, 1'b0, 4'h0, 1'b0};
    vecs[4]  = '{1'b1, 4'h2, 4'h4, 4'h0, 4'h1, 4'hD, 4'b0010, 2'd1, 1'b1, 4'h0, 1'b0};
    vecs[5]  = '{1'b1, 4'h2, 4'h4, 4'h0, 4'h1, 4'hD, 4'b0010, 2'd1, 1'b1, 4'h0, 1'b1};
    vecs[6]  = '{1'b1, 4'h2, 4'h4, 4'h0, 4'h1, 4'hD, 4'b0010, 2'd1, 1'b1, 4'h0, 1'b1};
    vecs[7]  = '{1'b1, 4'h0, 4'h4, 4'h0, 4'h1, 4'hD, 4'b0000, 2'd1, 1'b0, 4'h0, 1'b1};
    vecs[8]  = '{1'b1, 4'h0, 4'h4, 4'h0, 4'h1, 4'hD, 4'b0000, 2'd1, 1'b0, 4'h0, 1'b0};
    vecs[9]  = '{1'b1, 4'h4, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0100, 2'd2, 1'b1, 4'h0, 1'b0};
    vecs[10] = '{1'b1, 4'h4, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0100, 2'd2, 1'b1, 4'hF, 1'b1};
    vecs[11] = '{1'b1, 4'h9, 4'h8, 4'hD, 4'hF, 4'h0, 4'b1000, 2'd3, 1'b1, 4'hF, 1'b1};
    vecs[12] = '{1'b1, 4'h9, 4'h8, 4'hD, 4'hF, 4'h0, 4'b1000, 2'd3, 1'b1, 4'h0, 1'b1};
    vecs[13] = '{1'b1, 4'h1, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0001, 2'd0, 1'b1, 4'h0, 1'b1};
    vecs[14] = '{1'b1, 4'h1, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0001, 2'd0, 1'b1, 4'h8, 1'b1};
    vecs[15] = '{1'b1, 4'h0, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b0, 4'h8, 1'b1};
    vecs[16] = '{1'b1, 4'h0, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b0, 4'h8, 1'b0};
    vecs[17] = '{1'b1, 4'h2, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0010, 2'd1, 1'b1, 4'h8, 1'b0};
    vecs[18] = '{1'b1, 4'h2, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0010, 2'd1, 1'b1, 4'hD, 1'b1};
    vecs[19] = '{1'b0, 4'h2, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0000, 2'd0, 1'b0, 4'h0, 1'b0};
    vecs[20] = '{1'b1, 4'hA, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0010, 2'd1, 1'b1, 4'h0, 1'b0};
    vecs[21] = '{1'b1, 4'h0, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0000, 2'd1, 1'b0, 4'hD, 1'b1};
    vecs[22] = '{1'b1, 4'h0, 4'h8, 4'hD, 4'hF, 4'h0, 4'b0000, 2'd1, 1'b0, 4'hD, 1'b0};

    for (int i = 0; i < NV; i++) begin
      rst_n  = vecs[i].rstn;
      req    = vecs[i].req;
      dat[0] = vecs[i].da;
      dat[1] = vecs[i].db;
      dat[2] = vecs[i].dc;
      dat[3] = vecs[i].dd;
      step();
      check($sformatf("vec%0d", i), outs(),
            16'({vecs[i].gnt, vecs[i].sel, vecs[i].en, vecs[i].z, vecs[i].zv}));
    end

    // Rotation under full load: each owner exactly MAX_HOLD cycles, no bubble.
    rr_dat = '{4'h8, 4'hD, 4'hF, 4'h0};
    dat = rr_dat;
    rst_n = 1'b0; req = '0;
    step();
    rst_n = 1'b1; req = 4'hF;
    for (int i = 0; i < 5 * int'(MAX_HOLD); i++) begin
      step();
      owner = (i / int'(MAX_HOLD)) % 4;
      prev  = ((i - 1) / int'(MAX_HOLD)) % 4;
      exp_z  = (i == 0) ? 4'h0 : rr_dat[prev];
      exp_zv = (i != 0);
      check($sformatf("rr%0d", i), outs(),
            16'({4'(1 << owner), 2'(owner), 1'b1, exp_z, exp_zv}));
    end

    // Lone requester past expiry keeps being regranted.
    rst_n = 1'b0; req = '0;
    step();
    rst_n = 1'b1; req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("expiry%0d", i), 16'({gnt, sel, en}), 16'({4'b0100, 2'd2, 1'b1}));
    end
    req = '0;

`ifdef MUX_ARB_LOCK_EN
    // Locked owner outlives MAX_HOLD, handoff to d when a releases.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req = 4'b1001; lock = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("lock%0d", i), 16'({gnt, sel, en}), 16'({4'b0001, 2'd0, 1'b1}));
    end
    req = 4'b1000;
    step();
    check("lock_release", 16'({gnt, sel, en}), 16'({4'b1000, 2'd3, 1'b1}));
    lock = '0; req = '0;
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      rst_n = (i == 0 || $urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) lock = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) dat[k] = DW'($urandom);
      model_edge(rst_n, req, lock);
      step();
      check($sformatf("rand%0d", i), outs(), model_outs());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
